// File: rtl/nfc_rbuf_pkg.sv
// rtl/nfc_rbuf_pkg.sv - shared types and lane constants for the read-buffer write controller
// Optional feature macro: NFC_RBUF_BYTE_SWAP_EN (first byte of each pair to the high lane).
package nfc_rbuf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [1:0] LANE_LO = 2'b01;
    localparam logic [1:0] LANE_HI = 2'b10;

    localparam int LEN_W_DEF = 12;

    // Lane enable for the first (second=0) or second (second=1) byte of a word.
    function automatic logic [1:0] lane_en(input logic second);
`ifdef NFC_RBUF_BYTE_SWAP_EN
        return second ? LANE_LO : LANE_HI;
`else
        return second ? LANE_HI : LANE_LO;
`endif
    endfunction

endpackage

// File: rtl/nfc_rbuf_wr_ctrl_if.sv
// rtl/nfc_rbuf_wr_ctrl_if.sv - flash byte stream and buffer write port bundle
interface nfc_rbuf_wr_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 4
);
    logic             byte_vld;
    logic [7:0]       byte_data;
    logic             byte_rdy;
    logic [1:0]       ram_write;
    logic [ADDR-1:0]  ram_addr_wr;
    logic [WIDTH-1:0] ram_data_in;

    modport slave (
        input  byte_vld, byte_data,
        output byte_rdy, ram_write, ram_addr_wr, ram_data_in
    );

    modport master (
        output byte_vld, byte_data,
        input  byte_rdy, ram_write, ram_addr_wr, ram_data_in
    );
endinterface

// File: rtl/nfc_rbuf_occ_cnt.sv
// rtl/nfc_rbuf_occ_cnt.sv - buffer word occupancy counter with commit/free inputs
module nfc_rbuf_occ_cnt #(
    parameter int ADDR  = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          commit,
    input  logic          free,
    output logic [ADDR:0] cnt,
    output logic          full,
    output logic          empty
);
    localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);

    logic [ADDR:0] cnt_q, cnt_d;
    logic          free_ok;

    // A free on an empty buffer is dropped so the count never underflows.
    always_comb begin
        cnt_d   = cnt_q;
        free_ok = free & (cnt_q != '0);
        if (commit & ~free_ok) begin
            cnt_d = cnt_q + (ADDR+1)'(1);
        end else if (~commit & free_ok) begin
            cnt_d = cnt_q - (ADDR+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt   = cnt_q;
    assign full  = (cnt_q == DEPTH_C);
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/nfc_rbuf_wr_ctrl.sv
// rtl/nfc_rbuf_wr_ctrl.sv - packs flash bytes into 16-bit buffer words via per-lane writes
// Lane order selectable with NFC_RBUF_BYTE_SWAP_EN (see nfc_rbuf_pkg).
module nfc_rbuf_wr_ctrl
    import nfc_rbuf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ADDR  = 4,
    parameter int DEPTH = 16,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 word_free,
    nfc_rbuf_wr_ctrl_if.slave    bus,
    output logic [ADDR:0]        word_cnt,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 done
);
    state_t           state_q, state_d;
    logic [LEN_W-1:0] left_q, left_d;
    logic             second_q, second_d;
    logic [ADDR-1:0]  wptr_q, wptr_d;
    logic [1:0]       wr_q, wr_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;

    logic accept, last, commit;

    // Readiness looks at the registered count, so a pending low-lane byte never lands in a full buffer.
    assign bus.byte_rdy = (state_q == FILL) & ~full;
    assign accept       = bus.byte_vld & bus.byte_rdy;
    assign last         = (left_q == LEN_W'(1));
    assign commit       = accept & (second_q | last);

    always_comb begin
        state_d  = state_q;
        left_d   = left_q;
        second_d = second_q;
        wptr_d   = wptr_q;
        wr_d     = 2'b00;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d  = FILL;
                    left_d   = len;
                    second_d = 1'b0;
                end
            end
            FILL: begin
                if (accept) begin
                    wr_d     = lane_en(second_q);
                    addr_d   = wptr_q;
                    data_d   = {(WIDTH/8){bus.byte_data}};
                    left_d   = left_q - LEN_W'(1);
                    second_d = ~second_q;
                    if (commit) begin
                        wptr_d   = wptr_q + ADDR'(1);
                        second_d = 1'b0;
                    end
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            left_q   <= '0;
            second_q <= 1'b0;
            wptr_q   <= '0;
            wr_q     <= 2'b00;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            left_q   <= left_d;
            second_q <= second_d;
            wptr_q   <= wptr_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    nfc_rbuf_occ_cnt #(
        .ADDR  (ADDR),
        .DEPTH (DEPTH)
    ) u_occ (
        .clk    (clk),
        .rst_n  (rst_n),
        .commit (commit),
        .free   (word_free),
        .cnt    (word_cnt),
        .full   (full),
        .empty  (empty)
    );

    assign bus.ram_write   = wr_q;
    assign bus.ram_addr_wr = addr_q;
    assign bus.ram_data_in = data_q;
    assign busy            = (state_q == FILL);
    assign done            = done_q;

endmodule

// File: tb/tb_nfc_rbuf_wr_ctrl.sv
// tb/tb_nfc_rbuf_wr_ctrl.sv - self-checking bench for nfc_rbuf_wr_ctrl with a byte-level reference model
module tb_nfc_rbuf_wr_ctrl;
    localparam int WIDTH = 16;
    localparam int ADDR  = 4;
    localparam int DEPTH = 16;
    localparam int LEN_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             word_free;
    logic [ADDR:0]    word_cnt;
    logic             full, empty, busy, done;

    nfc_rbuf_wr_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    nfc_rbuf_wr_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .word_free (word_free),
        .bus       (bus),
        .word_cnt  (word_cnt),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: byte position within the transfer, words committed, ring write pointer.
    int          m_busy, m_left, m_idx, m_wptr, m_occ;
    logic        exp_rdy, obs_rdy, exp_done;
    logic [1:0]  exp_write;
    int          exp_addr;
    logic [15:0] exp_data;

    function automatic logic [1:0] exp_lane(input int idx);
`ifdef NFC_RBUF_BYTE_SWAP_EN
        return (idx % 2 == 0) ? 2'b10 : 2'b01;
`else
        return (idx % 2 == 0) ? 2'b01 : 2'b10;
`endif
    endfunction

    task automatic model_reset();
        m_busy = 0; m_left = 0; m_idx = 0; m_wptr = 0; m_occ = 0;
        exp_write = 2'b00; exp_addr = 0; exp_data = 16'h0; exp_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; word_free = 1'b0;
        bus.byte_vld = 1'b0; bus.byte_data = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drive one cycle of inputs, advance the model, and leave outputs sampled 1 time unit after the edge.
    task automatic step(input logic st, input logic [LEN_W-1:0] ln, input logic vld,
                        input logic [7:0] d, input logic fr);
        logic acc, cm, stv;
        int   dec;
        start = st; len = ln; bus.byte_vld = vld; bus.byte_data = d; word_free = fr;
        #1;
        obs_rdy   = bus.byte_rdy;
        exp_rdy   = (m_busy != 0) && (m_occ < DEPTH);
        acc       = vld && exp_rdy;
        exp_write = acc ? exp_lane(m_idx) : 2'b00;
        if (acc) begin
            exp_addr = m_wptr;
            exp_data = {d, d};
        end
        exp_done = acc && (m_left == 1);
        cm  = acc && ((m_idx % 2 == 1) || (m_left == 1));
        dec = (fr && m_occ > 0) ? 1 : 0;
        stv = (m_busy == 0) && st && (ln != 0);
        m_occ = m_occ + int'(cm) - dec;
        if (acc) begin
            m_idx++;
            m_left--;
            if (cm) m_wptr = (m_wptr + 1) % DEPTH;
            if (m_left == 0) m_busy = 0;
        end
        if (stv) begin
            m_busy = 1; m_left = int'(ln); m_idx = 0;
        end
        @(posedge clk); #1;
        start = 1'b0; word_free = 1'b0; bus.byte_vld = 1'b0;
    endtask

    task automatic test_reset();
        logic [32:0] obs;
        do_reset();
        obs = {bus.byte_rdy, bus.ram_write, bus.ram_addr_wr, bus.ram_data_in, word_cnt, full, empty, busy, done};
        checks++;
        if (obs !== {1'b0, 2'b00, 4'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs,
                     {1'b0, 2'b00, 4'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_len4();
        logic [7:0] b[4];
        int         ea[4];
        b  = '{8'h11, 8'h22, 8'h33, 8'h44};
        ea = '{0, 0, 1, 1};
        do_reset();
        step(1'b1, 12'd4, 1'b0, 8'h00, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL len4_busy_rise: got %b expected 1", busy); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, b[i], 1'b0);
            checks++;
            if (bus.ram_write !== exp_lane(i)) begin
                errors++; $display("FAIL len4_write[%0d]: got %b expected %b", i, bus.ram_write, exp_lane(i));
            end
            checks++;
            if (bus.ram_addr_wr !== 4'(ea[i])) begin
                errors++; $display("FAIL len4_addr[%0d]: got %0d expected %0d", i, bus.ram_addr_wr, ea[i]);
            end
            checks++;
            if (bus.ram_data_in !== {b[i], b[i]}) begin
                errors++; $display("FAIL len4_data[%0d]: got %h expected %h", i, bus.ram_data_in, {b[i], b[i]});
            end
            checks++;
            if (done !== (i == 3)) begin
                errors++; $display("FAIL len4_done[%0d]: got %b expected %b", i, done, (i == 3));
            end
        end
        checks++;
        if (word_cnt !== 5'd2 || busy !== 1'b0) begin
            errors++; $display("FAIL len4_end: got cnt=%0d busy=%b expected cnt=2 busy=0", word_cnt, busy);
        end
        step(1'b0, '0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (done !== 1'b0 || bus.ram_write !== 2'b00) begin
            errors++; $display("FAIL len4_single_pulse: got done=%b write=%b expected 0/00", done, bus.ram_write);
        end
    endtask

    task automatic test_len3();
        do_reset();
        step(1'b1, 12'd3, 1'b0, 8'h00, 1'b0);
        step(1'b0, '0, 1'b1, 8'hA1, 1'b0);
        step(1'b0, '0, 1'b1, 8'hB2, 1'b0);
        step(1'b0, '0, 1'b1, 8'hC3, 1'b0);
        checks++;
        if (bus.ram_write !== exp_lane(0) || bus.ram_addr_wr !== 4'd1 || bus.ram_data_in !== 16'hC3C3) begin
            errors++; $display("FAIL len3_tail: got write=%b addr=%0d data=%h expected write=%b addr=1 data=c3c3",
                               bus.ram_write, bus.ram_addr_wr, bus.ram_data_in, exp_lane(0));
        end
        checks++;
        if (done !== 1'b1 || word_cnt !== 5'd2) begin
            errors++; $display("FAIL len3_done: got done=%b cnt=%0d expected done=1 cnt=2", done, word_cnt);
        end
    endtask

    task automatic test_full();
        int  n = 0;
        logic seen_done = 1'b0;
        do_reset();
        step(1'b1, 12'd40, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 50; c++) begin
            step(1'b0, '0, 1'b1, 8'(n), 1'b0);
            if (obs_rdy) n++;
            else break;
        end
        checks++;
        if (n !== 32) begin errors++; $display("FAIL full_accept_count: got %0d expected 32", n); end
        checks++;
        if (full !== 1'b1 || word_cnt !== 5'd16 || bus.byte_rdy !== 1'b0) begin
            errors++; $display("FAIL full_state: got full=%b cnt=%0d rdy=%b expected 1/16/0", full, word_cnt, bus.byte_rdy);
        end
        for (int c = 0; c < 100 && !seen_done; c++) begin
            step(1'b0, '0, 1'b1, 8'(n), (c % 2 == 0));
            if (obs_rdy) n++;
            if (done) seen_done = 1'b1;
            checks++;
            if (bus.ram_write !== exp_write || obs_rdy !== exp_rdy) begin
                errors++; $display("FAIL full_drain[%0d]: got write=%b rdy=%b expected write=%b rdy=%b",
                                   c, bus.ram_write, obs_rdy, exp_write, exp_rdy);
            end
        end
        checks++;
        if (!seen_done || n !== 40) begin
            errors++; $display("FAIL full_finish: got done_seen=%b bytes=%0d expected 1/40", seen_done, n);
        end
    endtask

    task automatic test_word_free();
        do_reset();
        step(1'b1, 12'd4, 1'b0, 8'h00, 1'b0);
        step(1'b0, '0, 1'b1, 8'h01, 1'b0);
        step(1'b0, '0, 1'b1, 8'h02, 1'b0);
        step(1'b0, '0, 1'b1, 8'h03, 1'b0);
        step(1'b0, '0, 1'b1, 8'h04, 1'b1);
        checks++;
        if (word_cnt !== 5'd1) begin errors++; $display("FAIL free_on_commit: got %0d expected 1", word_cnt); end
        step(1'b0, '0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (word_cnt !== 5'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL free_to_empty: got cnt=%0d empty=%b expected 0/1", word_cnt, empty);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (word_cnt !== 5'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL free_underflow: got cnt=%0d empty=%b expected 0/1", word_cnt, empty);
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] obs;
        do_reset();
        step(1'b1, 12'd10, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 8'(8'h50 + i), 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        obs = {bus.byte_rdy, bus.ram_write, bus.ram_addr_wr, bus.ram_data_in, word_cnt, full, empty, busy, done};
        checks++;
        if (obs !== {1'b0, 2'b00, 4'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_mid_values: got %h expected %h", obs,
                               {1'b0, 2'b00, 4'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 12'd2, 1'b0, 8'h00, 1'b0);
        step(1'b0, '0, 1'b1, 8'h77, 1'b0);
        checks++;
        if (bus.ram_write !== exp_lane(0) || bus.ram_addr_wr !== 4'd0) begin
            errors++; $display("FAIL reset_mid_restart: got write=%b addr=%0d expected write=%b addr=0",
                               bus.ram_write, bus.ram_addr_wr, exp_lane(0));
        end
        step(1'b0, '0, 1'b1, 8'h78, 1'b0);
        checks++;
        if (word_cnt !== 5'd1 || done !== 1'b1) begin
            errors++; $display("FAIL reset_mid_cnt: got cnt=%0d done=%b expected 1/1", word_cnt, done);
        end
    endtask

    task automatic test_random();
        logic       st, vld, fr;
        logic [7:0] d;
        logic [LEN_W-1:0] ln;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            st  = ($urandom_range(0, 5) == 0);
            ln  = LEN_W'($urandom_range(0, 24));
            vld = ($urandom_range(0, 3) != 0);
            fr  = ($urandom_range(0, 4) < ((c / 200) % 2 == 0 ? 1 : 3));
            d   = 8'($urandom);
            step(st, ln, vld, d, fr);
            checks++;
            if (obs_rdy !== exp_rdy) begin
                errors++; $display("FAIL rand_rdy[%0d]: got %b expected %b", c, obs_rdy, exp_rdy);
            end
            checks++;
            if (bus.ram_write !== exp_write || done !== exp_done) begin
                errors++; $display("FAIL rand_write[%0d]: got write=%b done=%b expected write=%b done=%b",
                                   c, bus.ram_write, done, exp_write, exp_done);
            end
            if (exp_write != 2'b00) begin
                checks++;
                if (bus.ram_addr_wr !== 4'(exp_addr) || bus.ram_data_in !== exp_data) begin
                    errors++; $display("FAIL rand_addr_data[%0d]: got addr=%0d data=%h expected addr=%0d data=%h",
                                       c, bus.ram_addr_wr, bus.ram_data_in, exp_addr, exp_data);
                end
            end
            checks++;
            if (word_cnt !== 5'(m_occ) || busy !== (m_busy != 0) || full !== (m_occ == DEPTH) || empty !== (m_occ == 0)) begin
                errors++; $display("FAIL rand_occ[%0d]: got cnt=%0d busy=%b full=%b empty=%b expected cnt=%0d busy=%0d",
                                   c, word_cnt, busy, full, empty, m_occ, m_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_len4();
        test_len3();
        test_full();
        test_word_free();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule
